// File: rtl/mop_issue_sched.sv
// In-order micro-op issue scheduler: circular queue of decoded micro-ops plus a
// busy-register scoreboard; the head issues only when hazard-free, jumps and clflush serialise.
package mop_pkg;
  typedef enum logic [3:0] {
    M_NOP, M_ADD, M_SUB, M_LD, M_ST, M_JB, M_JZ, M_JNZ, M_JMP, M_CLFLUSH
  } opcode_t;
  localparam opcode_t M_JMIN = M_JB;
  localparam opcode_t M_JMAX = M_JMP;

  typedef logic [5:0] reg_id_t;
  localparam reg_id_t RNIL = 6'd0;
  localparam reg_id_t RAX  = 6'd1;
  localparam reg_id_t RBX  = 6'd2;
  localparam reg_id_t RCX  = 6'd3;
  localparam reg_id_t RDX  = 6'd4;

  typedef struct packed {
    opcode_t     opcode;
    reg_id_t     dst_id;
    reg_id_t     src0_id;
    reg_id_t     src1_id;
    logic [15:0] imm;
  } micro_op_t;
endpackage

module mop_issue_sched
  import mop_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NREGS   = 64,
  parameter int STALL_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enq_valid,
  input  micro_op_t                enq_mop,
  output logic                     enq_ready,
  output logic                     iss_valid,
  output micro_op_t                iss_mop,
  input  logic                     iss_ready,
  input  logic                     wb_valid,
  input  reg_id_t                  wb_reg_id,
  input  logic                     br_resolve,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [STALL_W-1:0]       stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_RUN, S_BR_WAIT} state_t;

  micro_op_t          q_mem [DEPTH];
  logic [AW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic [NREGS-1:0]   busy_q, busy_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  state_t             state_q, state_d;

  micro_op_t head_mop;
  logic      src0_busy, src1_busy, dst_busy;
  logic      head_ok, is_jump, is_clflush, do_enq, do_iss;

  assign head_mop   = q_mem[head_q];
  assign src0_busy  = (head_mop.src0_id != RNIL) && busy_q[head_mop.src0_id];
  assign src1_busy  = (head_mop.src1_id != RNIL) && busy_q[head_mop.src1_id];
  assign dst_busy   = (head_mop.dst_id  != RNIL) && busy_q[head_mop.dst_id];
  assign is_jump    = (head_mop.opcode >= M_JMIN) && (head_mop.opcode <= M_JMAX);
  assign is_clflush = (head_mop.opcode == M_CLFLUSH);
  // clflush waits for every outstanding write so it never overtakes a pending store/load
  assign head_ok    = !src0_busy && !src1_busy && !dst_busy && (!is_clflush || (busy_q == '0));

  assign iss_valid = (count_q != '0) && !flush && (state_q == S_RUN) && head_ok;
  assign enq_ready = (count_q != CW'(DEPTH)) && !flush;
  assign iss_mop   = head_mop;
  assign count     = count_q;
  assign stall_cnt = stall_q;
  assign do_enq    = enq_valid && enq_ready;
  assign do_iss    = iss_valid && iss_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    stall_d = stall_q;
    state_d = state_q;

    if (do_enq) tail_d = tail_q + AW'(1);
    if (do_iss) head_d = head_q + AW'(1);
    case ({do_enq, do_iss})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // set after clear so an issuing writer wins over a same-cycle writeback
    if (wb_valid) busy_d[wb_reg_id] = 1'b0;
    if (do_iss && (head_mop.dst_id != RNIL)) busy_d[head_mop.dst_id] = 1'b1;

    if ((count_q != '0) && (state_q == S_RUN) && !flush && !head_ok && (stall_q != '1))
      stall_d = stall_q + STALL_W'(1);

    if (flush) begin
      head_d  = tail_q;
      count_d = '0;
      state_d = S_RUN;
    end else if (state_q == S_BR_WAIT) begin
      if (br_resolve) state_d = S_RUN;
    end else if (do_iss && is_jump) begin
      state_d = S_BR_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) q_mem[tail_q] <= enq_mop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      stall_q <= '0;
      state_q <= S_RUN;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
      state_q <= state_d;
    end
  end
endmodule
